// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters using round-robin
// arbitration. A request is accepted with a valid/ready handshake. Its operands
// and mode are registered onto the ALU inputs. The ALU result and zero flag are
// captured one cycle later. They are returned to the granted requester through a
// valid/ready response port.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_reqN_valid/a/b/mode          request N: operation and operands
//   o_reqN_ready                   request N accepted this cycle
//   o_rspN_valid/result/zero/err   response N and its captured ALU outputs
//   i_rspN_ready                   requester N consumes its response
//   o_alu_a/b/mode                 registered operands driving the ALU
//   i_alu_result/zero              combinational ALU outputs
//
// Build option:
//   ALU_ARB_MODE_CHECK_EN  When this macro is defined, the mode is checked at
//                          acceptance. The legal modes are 0x00, 0x02, 0x03 and
//                          0x20-0x29. An illegal mode skips the ALU and returns
//                          result=0, zero=0, err=1. When the macro is undefined,
//                          err is tied to 0.
module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MODE_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  input  logic [DATA_WIDTH-1:0] i_req0_a,
  input  logic [DATA_WIDTH-1:0] i_req0_b,
  input  logic [MODE_WIDTH-1:0] i_req0_mode,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [DATA_WIDTH-1:0] i_req1_a,
  input  logic [DATA_WIDTH-1:0] i_req1_b,
  input  logic [MODE_WIDTH-1:0] i_req1_mode,
  output logic                  o_req1_ready,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_result,
  output logic                  o_rsp0_zero,
  output logic                  o_rsp0_err,
  input  logic                  i_rsp0_ready,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_result,
  output logic                  o_rsp1_zero,
  output logic                  o_rsp1_err,
  input  logic                  i_rsp1_ready,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [MODE_WIDTH-1:0] o_alu_mode,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  prio;
  logic                  grant;
  logic                  winner;
  logic                  accept;
  logic                  rsp_ready_g;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [MODE_WIDTH-1:0] sel_mode;

  // Per-requester response registers, indexed by grant
  logic [DATA_WIDTH-1:0] rsp_result [2];
  logic [1:0]            rsp_zero;
  logic [1:0]            rsp_valid;

`ifdef ALU_ARB_MODE_CHECK_EN
  logic [1:0] rsp_err;
  logic       mode_ok;

  // Legal modes are 0x00, 0x02, 0x03 and 0x20-0x29. All other codes are rejected.
  function automatic logic mode_legal(input logic [MODE_WIDTH-1:0] mode);
    int unsigned m;
    m = 32'(mode);
    return (m == 32'h00) || (m == 32'h02) || (m == 32'h03) ||
           ((m >= 32'h20) && (m <= 32'h29));
  endfunction
`endif

  // Arbitration picks a winner and selects that requester's operands.
  // When both requesters are valid, prio breaks the tie.
  // When only one is valid, that one wins regardless of prio.
  always_comb begin
    winner      = (i_req0_valid && i_req1_valid) ? prio : i_req1_valid;
    sel_a       = winner ? i_req1_a    : i_req0_a;
    sel_b       = winner ? i_req1_b    : i_req0_b;
    sel_mode    = winner ? i_req1_mode : i_req0_mode;
    rsp_ready_g = grant  ? i_rsp1_ready : i_rsp0_ready;
`ifdef ALU_ARB_MODE_CHECK_EN
    mode_ok     = mode_legal(sel_mode);
`endif
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and request-ready logic.
  // Ready is held low while reset is asserted, so no handshake can complete
  // on a reset edge.
  always_comb begin
    state_nxt    = state;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        o_req0_ready = i_rst_n && i_req0_valid && !winner;
        o_req1_ready = i_rst_n && i_req1_valid &&  winner;
        accept       = o_req0_ready || o_req1_ready;
        if (accept) begin
`ifdef ALU_ARB_MODE_CHECK_EN
          state_nxt = mode_ok ? EXEC : RESP;
`else
          state_nxt = EXEC;
`endif
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready_g) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers:
  //   - On acceptance, the operands are latched onto the ALU inputs.
  //   - In EXEC, the ALU outputs are captured into the granted response slot.
  //   - When the response is consumed, prio passes to the other requester.
  // The ALU input registers keep their last values while idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prio          <= 1'b0;
      grant         <= 1'b0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_mode    <= '0;
      rsp_result[0] <= '0;
      rsp_result[1] <= '0;
      rsp_zero      <= '0;
      rsp_valid     <= '0;
`ifdef ALU_ARB_MODE_CHECK_EN
      rsp_err       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_alu_a    <= sel_a;
            o_alu_b    <= sel_b;
            o_alu_mode <= sel_mode;
            grant      <= winner;
`ifdef ALU_ARB_MODE_CHECK_EN
            if (!mode_ok) begin
              rsp_result[winner] <= '0;
              rsp_zero[winner]   <= 1'b0;
              rsp_err[winner]    <= 1'b1;
              rsp_valid[winner]  <= 1'b1;
            end
`endif
          end
        end
        EXEC: begin
          rsp_result[grant] <= i_alu_result;
          rsp_zero[grant]   <= i_alu_zero;
          rsp_valid[grant]  <= 1'b1;
`ifdef ALU_ARB_MODE_CHECK_EN
          rsp_err[grant]    <= 1'b0;
`endif
        end
        RESP: begin
          if (rsp_ready_g) begin
            rsp_valid[grant] <= 1'b0;
            prio             <= ~grant;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp0_valid  = rsp_valid[0];
  assign o_rsp1_valid  = rsp_valid[1];
  assign o_rsp0_result = rsp_result[0];
  assign o_rsp1_result = rsp_result[1];
  assign o_rsp0_zero   = rsp_zero[0];
  assign o_rsp1_zero   = rsp_zero[1];
`ifdef ALU_ARB_MODE_CHECK_EN
  assign o_rsp0_err    = rsp_err[0];
  assign o_rsp1_err    = rsp_err[1];
`else
  assign o_rsp0_err    = 1'b0;
  assign o_rsp1_err    = 1'b0;
`endif

endmodule
